// File: rtl/ibuffer_pkg.sv
// Shared defaults, FSM state encoding and the diagonal element-select helper
// for the ping-pong input skew buffer.
package ibuffer_pkg;
  localparam int N_DEF     = 4;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;
  localparam int ODW_DEF   = 4;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  // Element index a column should present at stream step cnt; out of range means idle.
  function automatic int idx(input int cnt, input int c);
    return cnt - c;
  endfunction
endpackage

// File: rtl/ibuffer_skew_col.sv
// One array column: both bank words plus the registered skewed element/valid.
module ibuffer_skew_col
  import ibuffer_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNTW  = 4,
  parameter int COL   = 0
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                i_we,
  input  logic                i_wr_bank,
  input  logic [DEPTH*DW-1:0] i_word,
  input  logic                i_active,
  input  logic                i_rd_bank,
  input  logic [CNTW-1:0]     i_cnt,
  output logic [DW-1:0]       o_elem,
  output logic                o_valid
);
  logic [DEPTH*DW-1:0] r_bank [2];
  logic [DW-1:0]       r_elem;
  logic                r_valid;

  int                  w_idx;
  logic                w_hit;
  logic [DEPTH*DW-1:0] w_word;
  logic [DW-1:0]       w_elem;

  // Element 0 sits in the MSBs of the packed column word.
  always_comb begin
    w_idx  = idx(int'(i_cnt), COL);
    w_hit  = i_active && (w_idx >= 0) && (w_idx < DEPTH);
    w_word = r_bank[i_rd_bank];
    w_elem = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (w_hit && (w_idx == j)) w_elem = w_word[(DEPTH-1-j)*DW +: DW];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
      r_elem    <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (i_we) r_bank[i_wr_bank] <= i_word;
      r_elem  <= w_elem;
      r_valid <= w_hit;
    end
  end

  assign o_elem  = r_elem;
  assign o_valid = r_valid;
endmodule

// File: rtl/ibuffer_skew_pp.sv
// Ping-pong skew buffer: loader fills one bank while the other streams diagonally
// into the MAC array. Load side: LOAD_EN/LOAD_COMMIT take effect only while LOAD_READY=1.
module ibuffer_skew_pp
  import ibuffer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ODW   = ODW_DEF
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 LOAD_EN,
  input  logic [$clog2(N)-1:0] LOAD_COL,
  input  logic [DEPTH*DW-1:0]  LOAD_WORD,
  input  logic                 LOAD_COMMIT,
  output logic                 LOAD_READY,
  input  logic                 START_CALC,
  output logic                 CALC_BUSY,
  output logic [N*DW-1:0]      IROW_o,
  output logic [N-1:0]         ICOL_VALID,
  output logic                 TILE_DONE,
  input  logic [ODW-1:0]       ODST_i,
  output logic [ODW-1:0]       ODST_o,
  output state_t               o_dbg_state
);
  localparam int L    = DEPTH + N - 1;
  localparam int CNTW = $clog2(L + 1);

  state_t          r_state, w_state_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]      r_full;
  logic            r_wr_bank, r_rd_bank;
  logic            r_done;
  logic [ODW-1:0]  r_odst;

  logic w_ready, w_wr, w_commit, w_accept, w_last, w_end;

  // Held low during reset so every output reads 0 while RSTN is asserted.
  assign w_ready  = RSTN & ~r_full[r_wr_bank];
  assign w_wr     = LOAD_EN & w_ready & (int'(LOAD_COL) < N);
  assign w_commit = LOAD_COMMIT & w_ready;
  assign w_last   = (r_state == STREAM) && (r_cnt == CNTW'(L - 1));
  // cnt runs one step past the last element; that step drains the outputs and frees the bank.
  assign w_end    = (r_state == STREAM) && (r_cnt == CNTW'(L));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (START_CALC && r_full[r_rd_bank]) begin
          w_state_nxt = STREAM;
          w_cnt_nxt   = '0;
          w_accept    = 1'b1;
        end
      end
      STREAM: begin
        if (w_end) w_state_nxt = IDLE;
        else       w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_done    <= 1'b0;
      r_odst    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_last;
      // Commit and stream end always target different banks.
      if (w_commit) r_full[r_wr_bank] <= 1'b1;
      if (w_end)    r_full[r_rd_bank] <= 1'b0;
      if (w_commit) r_wr_bank <= ~r_wr_bank;
      if (w_end)    r_rd_bank <= ~r_rd_bank;
      if (w_accept) r_odst <= ODST_i;
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_col
    ibuffer_skew_col #(
      .DW(DW), .DEPTH(DEPTH), .CNTW(CNTW), .COL(c)
    ) u_col (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .i_we      (w_wr && (int'(LOAD_COL) == c)),
      .i_wr_bank (r_wr_bank),
      .i_word    (LOAD_WORD),
      .i_active  (r_state == STREAM),
      .i_rd_bank (r_rd_bank),
      .i_cnt     (r_cnt),
      .o_elem    (IROW_o[(N-1-c)*DW +: DW]),
      .o_valid   (ICOL_VALID[c])
    );
  end

  assign LOAD_READY  = w_ready;
  assign CALC_BUSY   = (r_state == STREAM);
  assign TILE_DONE   = r_done;
  assign ODST_o      = r_odst;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_ibuffer_skew_pp.sv
// Scoreboard bench for ibuffer_skew_pp: default 4x8x4 instance plus an 8x16x2 instance.
`timescale 1ns/1ps
module tb_ibuffer_skew_pp;
  import ibuffer_pkg::*;
  localparam int W  = 4 + 32 + 1;
  localparam int W8 = 8 + 128 + 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RSTN;

  logic        LOAD_EN, LOAD_COMMIT, START_CALC, LOAD_READY, CALC_BUSY, TILE_DONE;
  logic [1:0]  LOAD_COL;
  logic [31:0] LOAD_WORD, IROW_o;
  logic [3:0]  ICOL_VALID, ODST_i, ODST_o;
  state_t      dbg;

  logic         l8_en, l8_commit, s8_calc, l8_ready, b8_busy, d8_done;
  logic [2:0]   l8_col;
  logic [31:0]  l8_word;
  logic [127:0] r8;
  logic [7:0]   v8;
  logic [3:0]   o8;
  logic [3:0]   odst8_i;
  state_t       dbg8;

  ibuffer_skew_pp dut (
    .CLK(CLK), .RSTN(RSTN), .LOAD_EN(LOAD_EN), .LOAD_COL(LOAD_COL), .LOAD_WORD(LOAD_WORD),
    .LOAD_COMMIT(LOAD_COMMIT), .LOAD_READY(LOAD_READY), .START_CALC(START_CALC),
    .CALC_BUSY(CALC_BUSY), .IROW_o(IROW_o), .ICOL_VALID(ICOL_VALID), .TILE_DONE(TILE_DONE),
    .ODST_i(ODST_i), .ODST_o(ODST_o), .o_dbg_state(dbg)
  );

  ibuffer_skew_pp #(.N(8), .DW(16), .DEPTH(2), .ODW(4)) dut8 (
    .CLK(CLK), .RSTN(RSTN), .LOAD_EN(l8_en), .LOAD_COL(l8_col), .LOAD_WORD(l8_word),
    .LOAD_COMMIT(l8_commit), .LOAD_READY(l8_ready), .START_CALC(s8_calc),
    .CALC_BUSY(b8_busy), .IROW_o(r8), .ICOL_VALID(v8), .TILE_DONE(d8_done),
    .ODST_i(odst8_i), .ODST_o(o8), .o_dbg_state(dbg8)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] mk_row(input logic [3:0][31:0] w, input int t);
    logic [3:0]  v;
    logic [31:0] r;
    int d;
    v = '0;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      d = t - c;
      if (d >= 0 && d <= 3) begin
        v[c] = 1'b1;
        r[(3-c)*8 +: 8] = w[c][(3-d)*8 +: 8];
      end
    end
    return {v, r, (t == 6)};
  endfunction

  function automatic logic [W8-1:0] mk_row8(input logic [7:0][31:0] w, input int t);
    logic [7:0]   v;
    logic [127:0] r;
    int d;
    v = '0;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      d = t - c;
      if (d >= 0 && d <= 1) begin
        v[c] = 1'b1;
        r[(7-c)*16 +: 16] = w[c][(1-d)*16 +: 16];
      end
    end
    return {v, r, (t == 8)};
  endfunction

  // ---------------- scoreboards / monitors ----------------
  logic [W-1:0]  exp_q[$];
  logic [W8-1:0] exp8_q[$];

  always @(negedge CLK) begin : mon
    logic [W-1:0] got, e;
    if (ICOL_VALID != 4'd0 || TILE_DONE) begin
      got = {ICOL_VALID, IROW_o, TILE_DONE};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL row4 unexpected: got %h expected no output", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL row4: got %h expected %h", got, e);
        end
      end
    end
  end

  always @(negedge CLK) begin : mon8
    logic [W8-1:0] got, e;
    if (v8 != 8'd0 || d8_done) begin
      got = {v8, r8, d8_done};
      n_cmp++;
      if (exp8_q.size() == 0) begin
        n_fail++;
        $display("FAIL row8 unexpected: got %h expected no output", got);
      end else begin
        e = exp8_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL row8: got %h expected %h", got, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_tile(input logic [3:0][31:0] w);
    for (int c = 0; c < 4; c++) begin
      LOAD_EN = 1'b1; LOAD_COL = 2'(c); LOAD_WORD = w[c];
      tick();
    end
    LOAD_EN = 1'b0;
  endtask

  task automatic commit();
    LOAD_COMMIT = 1'b1;
    tick();
    LOAD_COMMIT = 1'b0;
  endtask

  task automatic push_tile(input logic [3:0][31:0] w);
    for (int t = 0; t < 7; t++) exp_q.push_back(mk_row(w, t));
  endtask

  task automatic start_pulse(input logic [3:0] tag);
    ODST_i = tag; START_CALC = 1'b1;
    tick();
    START_CALC = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (CALC_BUSY && n < 40) begin tick(); n++; end
    check(name, CALC_BUSY, 1'b0);
  endtask

  logic [3:0][31:0] t1, ta, tb, tf1, tf2, tr;
  logic [7:0][31:0] w8;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nv, c7_first, c7_cnt;
    t1  = {32'h31323334, 32'h21222324, 32'h11121314, 32'h01020304};
    ta  = {32'hD0D1D2D3, 32'hC0C1C2C3, 32'hB0B1B2B3, 32'hA0A1A2A3};
    tb  = {32'h4C4D4E4F, 32'h48494A4B, 32'h44454647, 32'h40414243};
    tf1 = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
    tf2 = {32'h9F9E9D9C, 32'h9B9A9998, 32'h97969594, 32'h93929190};
    tr  = {32'h5A5B5C5D, 32'h6A6B6C6D, 32'h7A7B7C7D, 32'h8A8B8C8D};
    RSTN = 1'b0; LOAD_EN = 0; LOAD_COMMIT = 0; START_CALC = 0;
    LOAD_COL = '0; LOAD_WORD = '0; ODST_i = '0;
    l8_en = 0; l8_commit = 0; s8_calc = 0; l8_col = '0; l8_word = '0; odst8_i = '0;

    // reset state
    repeat (3) @(posedge CLK);
    #2;
    check("rst LOAD_READY", LOAD_READY, 0);
    check("rst CALC_BUSY", CALC_BUSY, 0);
    check("rst ICOL_VALID", ICOL_VALID, 0);
    check("rst IROW_o", IROW_o, 0);
    check("rst TILE_DONE", TILE_DONE, 0);
    check("rst ODST_o", ODST_o, 0);
    check("rst state", dbg, IDLE);
    @(negedge CLK); RSTN = 1'b1;
    tick();
    check("ready after reset", LOAD_READY, 1);

    // basic tile with hand-computed rows
    load_tile(t1);
    commit();
    check("ready after 1 commit", LOAD_READY, 1);
    exp_q.push_back({4'b0001, 32'h01000000, 1'b0});
    exp_q.push_back({4'b0011, 32'h02110000, 1'b0});
    exp_q.push_back({4'b0111, 32'h03122100, 1'b0});
    exp_q.push_back({4'b1111, 32'h04132231, 1'b0});
    exp_q.push_back({4'b1110, 32'h00142332, 1'b0});
    exp_q.push_back({4'b1100, 32'h00002433, 1'b0});
    exp_q.push_back({4'b1000, 32'h00000034, 1'b1});
    start_pulse(4'h5);
    check("tile1 busy", CALC_BUSY, 1);
    check("tile1 ODST_o", ODST_o, 4'h5);
    check("tile1 state", dbg, STREAM);
    wait_idle("tile1 end");
    check("tile1 drained", exp_q.size(), 0);

    // START_CALC with nothing committed
    ODST_i = 4'h7; START_CALC = 1'b1;
    tick();
    START_CALC = 1'b0;
    check("empty start busy", CALC_BUSY, 0);
    check("empty start valid", ICOL_VALID, 0);
    check("empty start ODST_o", ODST_o, 4'h5);
    tick();
    check("empty start valid later", ICOL_VALID, 0);

    // ping-pong: fill B while A streams, START_CALC held high throughout
    load_tile(ta);
    commit();
    push_tile(ta);
    push_tile(tb);
    ODST_i = 4'hA; START_CALC = 1'b1;
    tick();
    ODST_i = 4'hB;
    check("pp A busy", CALC_BUSY, 1);
    check("pp A ODST_o", ODST_o, 4'hA);
    for (int c = 0; c < 4; c++) begin
      check("pp ready during stream", LOAD_READY, 1);
      LOAD_EN = 1'b1; LOAD_COL = 2'(c); LOAD_WORD = tb[c];
      tick();
    end
    LOAD_EN = 1'b0;
    check("pp ready before commit", LOAD_READY, 1);
    commit();
    check("pp ODST_o held", ODST_o, 4'hA);
    n = 0;
    while (CALC_BUSY && n < 40) begin tick(); n++; end
    check("pp A ended", CALC_BUSY, 0);
    n = 0;
    while (!CALC_BUSY && n < 10) begin tick(); n++; end
    check("pp bubble cycles", n, 1);
    check("pp B ODST_o", ODST_o, 4'hB);
    START_CALC = 1'b0;
    wait_idle("pp B end");
    check("pp drained", exp_q.size(), 0);

    // both banks full: extra load is dropped
    load_tile(tf1);
    commit();
    load_tile(tf2);
    commit();
    check("full ready", LOAD_READY, 0);
    LOAD_EN = 1'b1; LOAD_COL = 2'd0; LOAD_WORD = 32'hDEADBEEF;
    tick();
    LOAD_EN = 1'b0;
    push_tile(tf1);
    push_tile(tf2);
    start_pulse(4'h3);
    check("full ready during stream", LOAD_READY, 0);
    wait_idle("full t1 end");
    check("full ready after free", LOAD_READY, 1);
    start_pulse(4'h4);
    check("full t2 ODST_o", ODST_o, 4'h4);
    wait_idle("full t2 end");
    check("full drained", exp_q.size(), 0);

    // reset mid-stream at cnt=3
    load_tile(tr);
    commit();
    for (int t = 0; t < 3; t++) exp_q.push_back(mk_row(tr, t));
    start_pulse(4'h9);
    repeat (3) tick();
    @(negedge CLK);
    #1; RSTN = 1'b0;
    #1;
    check("midrst valid", ICOL_VALID, 0);
    check("midrst IROW_o", IROW_o, 0);
    check("midrst busy", CALC_BUSY, 0);
    check("midrst ODST_o", ODST_o, 0);
    check("midrst ready", LOAD_READY, 0);
    check("midrst rows seen", exp_q.size(), 0);
    @(negedge CLK); RSTN = 1'b1;
    tick();
    START_CALC = 1'b1;
    tick();
    START_CALC = 1'b0;
    check("postrst start ignored", CALC_BUSY, 0);
    check("postrst valid", ICOL_VALID, 0);

    // N=8, DW=16, DEPTH=2 instance
    for (int c = 0; c < 8; c++) w8[c] = {4'(c), 12'h0A1, 4'(c), 12'h0B2};
    for (int c = 0; c < 8; c++) begin
      l8_en = 1'b1; l8_col = 3'(c); l8_word = w8[c];
      tick();
    end
    l8_en = 1'b0;
    l8_commit = 1'b1; tick(); l8_commit = 1'b0;
    for (int t = 0; t < 9; t++) exp8_q.push_back(mk_row8(w8, t));
    s8_calc = 1'b1; tick(); s8_calc = 1'b0;
    nv = 0; c7_first = 0; c7_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (v8 != 8'd0) nv++;
      if (v8[7]) begin
        c7_cnt++;
        if (c7_first == 0) c7_first = i;
      end
    end
    check("n8 stream cycles", nv, 9);
    check("n8 col7 first cycle", c7_first, 8);
    check("n8 col7 cycles", c7_cnt, 2);
    check("n8 idle after", b8_busy, 0);
    check("n8 drained", exp8_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
